// File: rtl/sim_ctrl_pkg.sv
// Shared status codes, end causes and sequencer states for the simulation
// end-of-test controller.
package sim_ctrl_pkg;

    localparam logic [15:0] PASSED  = 16'h900d;
    localparam logic [15:0] FAILED  = 16'hbaad;
    localparam logic [15:0] IN_TEST = 16'h4354;
    localparam logic [15:0] IN_WFI  = 16'h1d1e;
    localparam logic [15:0] BOOTED  = 16'hb090;

    typedef enum logic [1:0] {
        SW_PASS   = 2'd0,
        SW_FAIL   = 2'd1,
        GPIO_PASS = 2'd2,
        TIMEOUT   = 2'd3
    } end_cause_e;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        UART_DRAIN = 2'd1,
        FLUSH      = 2'd2,
        FINISH     = 2'd3
    } state_e;

    function automatic logic cause_is_pass(input end_cause_e cause);
        return (cause == SW_PASS) || (cause == GPIO_PASS);
    endfunction

endpackage

// File: rtl/uart_idle_det.sv
// Flags the cycle on which the UART TX line completes UartIdleCycles
// consecutive high cycles while enabled.
module uart_idle_det #(
    parameter int unsigned UartIdleCycles = 400
) (
    input  logic clk_sys,
    input  logic rst_sys_n,
    input  logic enable,
    input  logic line,
    output logic idle
);
    localparam int unsigned IW = $clog2(UartIdleCycles) + 1;
    localparam logic [IW-1:0] IDLE_LAST = IW'(UartIdleCycles - 1);

    logic [IW-1:0] idle_cnt;

    // Pulse on the high cycle that would take the count to UartIdleCycles,
    // so a line held high yields exactly UartIdleCycles cycles of drain.
    assign idle = enable && line && (idle_cnt == IDLE_LAST);

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            idle_cnt <= '0;
        end else if (!enable || !line || idle) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + IW'(1);
        end
    end

endmodule

// File: rtl/sim_finish_ctrl.sv
// End-of-test sequencer: picks the first pass/fail cause, waits for the UART
// to go idle plus a flush period, then raises a sticky finish request.
module sim_finish_ctrl
    import sim_ctrl_pkg::*;
#(
    parameter logic [31:0]      StatusAddr     = 32'h0,
    parameter logic [31:0]      GpioSig        = 32'hDEADBEEF,
    parameter int unsigned      UartIdleCycles = 400,
    parameter int unsigned      DrainCycles    = 8,
    parameter longint unsigned  TimeoutCycles  = 0,
    parameter int unsigned      CntW           = 40
) (
    input  logic            clk_sys,
    input  logic            rst_sys_n,
    input  logic            wr_valid_i,
    input  logic [31:0]     wr_addr_i,
    input  logic [15:0]     wr_data_i,
    input  logic [31:0]     gpio_i,
    input  logic            uart_tx_i,
    output logic [15:0]     status_o,
    output logic            test_done_o,
    output logic            test_passed_o,
    output logic [1:0]      end_cause_o,
    output logic            finish_req_o,
    output logic [CntW-1:0] cycle_count_o
);
    localparam int unsigned     FW          = $clog2(DrainCycles) + 1;
    localparam logic [FW-1:0]   FLUSH_LAST  = FW'(DrainCycles - 1);
    localparam bit              TIMEOUT_EN  = (TimeoutCycles != 0);
    localparam logic [CntW-1:0] TIMEOUT_HIT = CntW'(TimeoutCycles - 1);

    state_e        state;
    end_cause_e    cause_q;
    end_cause_e    ev_cause;
    logic          ev_hit;
    logic          wr_hit;
    logic          uart_idle;
    logic [FW-1:0] flush_cnt;

    assign wr_hit      = wr_valid_i && (wr_addr_i == StatusAddr);
    assign end_cause_o = cause_q;

    // Priority order SW_FAIL > TIMEOUT > SW_PASS > GPIO_PASS.
    always_comb begin
        ev_hit   = 1'b1;
        ev_cause = SW_PASS;
        if (wr_hit && (wr_data_i == FAILED)) begin
            ev_cause = SW_FAIL;
        end else if (TIMEOUT_EN && (cycle_count_o == TIMEOUT_HIT)) begin
            ev_cause = TIMEOUT;
        end else if (wr_hit && (wr_data_i == PASSED)) begin
            ev_cause = SW_PASS;
        end else if (gpio_i == GpioSig) begin
            ev_cause = GPIO_PASS;
        end else begin
            ev_hit = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            status_o <= '0;
        end else if (wr_hit) begin
            status_o <= wr_data_i;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            cycle_count_o <= '0;
        end else if (cycle_count_o != '1) begin
            cycle_count_o <= cycle_count_o + CntW'(1);
        end
    end

    uart_idle_det #(
        .UartIdleCycles(UartIdleCycles)
    ) u_uart_idle_det (
        .clk_sys  (clk_sys),
        .rst_sys_n(rst_sys_n),
        .enable   (state == UART_DRAIN),
        .line     (uart_tx_i),
        .idle     (uart_idle)
    );

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state         <= RUN;
            cause_q       <= SW_PASS;
            test_done_o   <= 1'b0;
            test_passed_o <= 1'b0;
            finish_req_o  <= 1'b0;
            flush_cnt     <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (ev_hit) begin
                        state         <= UART_DRAIN;
                        cause_q       <= ev_cause;
                        test_done_o   <= 1'b1;
                        test_passed_o <= cause_is_pass(ev_cause);
                    end
                end
                UART_DRAIN: begin
                    if (uart_idle) begin
                        state     <= FLUSH;
                        flush_cnt <= '0;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == FLUSH_LAST) begin
                        state        <= FINISH;
                        finish_req_o <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt + FW'(1);
                    end
                end
                FINISH: begin
                    finish_req_o <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sim_finish_ctrl.sv
// Randomized episodes against a per-episode reference model; expected done and
// finish events are queued up front and popped by an independent monitor.
module tb_sim_finish_ctrl;

    localparam logic [31:0] SA   = 32'h0;
    localparam logic [31:0] SIG  = 32'hDEADBEEF;
    localparam int          U    = 20;
    localparam int          D    = 4;
    localparam int          TO   = 100;
    localparam int          CW   = 40;
    localparam int          N    = 170;
    localparam int          NEP  = 30;

    localparam logic [15:0] C_PASS = 16'h900d;
    localparam logic [15:0] C_FAIL = 16'hbaad;
    localparam logic [15:0] C_TEST = 16'h4354;
    localparam logic [15:0] C_WFI  = 16'h1d1e;
    localparam logic [15:0] C_BOOT = 16'hb090;

    logic          clk_sys = 1'b0;
    logic          rst_sys_n;
    logic          wr_valid_i;
    logic [31:0]   wr_addr_i;
    logic [15:0]   wr_data_i;
    logic [31:0]   gpio_i;
    logic          uart_tx_i;
    logic [15:0]   status_o;
    logic          test_done_o;
    logic          test_passed_o;
    logic [1:0]    end_cause_o;
    logic          finish_req_o;
    logic [CW-1:0] cycle_count_o;

    sim_finish_ctrl #(
        .StatusAddr    (SA),
        .GpioSig       (SIG),
        .UartIdleCycles(U),
        .DrainCycles   (D),
        .TimeoutCycles (TO),
        .CntW          (CW)
    ) dut (
        .clk_sys      (clk_sys),
        .rst_sys_n    (rst_sys_n),
        .wr_valid_i   (wr_valid_i),
        .wr_addr_i    (wr_addr_i),
        .wr_data_i    (wr_data_i),
        .gpio_i       (gpio_i),
        .uart_tx_i    (uart_tx_i),
        .status_o     (status_o),
        .test_done_o  (test_done_o),
        .test_passed_o(test_passed_o),
        .end_cause_o  (end_cause_o),
        .finish_req_o (finish_req_o),
        .cycle_count_o(cycle_count_o)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        bit          is_fin;
        int          cyc;
        logic [15:0] status;
        logic [1:0]  cause;
        bit          passed;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ep_cyc;

    logic        e_wv [N];
    logic [31:0] e_wa [N];
    logic [15:0] e_wd [N];
    logic [31:0] e_gp [N];
    logic        e_ut [N];

    int          m_t;
    int          m_f;
    logic [1:0]  m_cause;

    // Edges since reset release; after edge k this equals the DUT cycle count.
    always @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) ep_cyc <= 0;
        else            ep_cyc <= ep_cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [15:0] last_status(input int upto);
        logic [15:0] s = '0;
        for (int n = 0; n < N; n++) begin
            if (n <= upto && e_wv[n] && e_wa[n] == SA) s = e_wd[n];
        end
        return s;
    endfunction

    // Reference: first end event by priority, then the first run of U high
    // UART cycles after it, then D flush cycles.
    task automatic run_model();
        int run;
        m_t = -1;
        m_f = -1;
        m_cause = 2'd0;
        for (int n = 0; n < N; n++) begin
            bit hit;
            hit = e_wv[n] && (e_wa[n] == SA);
            if (hit && e_wd[n] == C_FAIL)      begin m_t = n; m_cause = 2'd1; break; end
            if (n == TO - 1)                   begin m_t = n; m_cause = 2'd3; break; end
            if (hit && e_wd[n] == C_PASS)      begin m_t = n; m_cause = 2'd0; break; end
            if (e_gp[n] == SIG)                begin m_t = n; m_cause = 2'd2; break; end
        end
        if (m_t >= 0) begin
            run = 0;
            for (int n = m_t + 1; n < N; n++) begin
                run = e_ut[n] ? run + 1 : 0;
                if (run == U) begin m_f = n + 1 + D; break; end
            end
        end
    endtask

    task automatic push_expected(input int rst_at);
        exp_t e;
        int lim;
        lim = (rst_at < N) ? rst_at : N;
        if (m_t >= 0 && m_t + 1 <= lim) begin
            e.is_fin = 1'b0;
            e.cyc    = m_t + 1;
            e.status = last_status(m_t);
            e.cause  = m_cause;
            e.passed = (m_cause == 2'd0) || (m_cause == 2'd2);
            exp_q.push_back(e);
        end
        if (m_f >= 0 && m_f <= lim) begin
            e.is_fin = 1'b1;
            e.cyc    = m_f;
            e.status = last_status(m_f - 1);
            e.cause  = m_cause;
            e.passed = (m_cause == 2'd0) || (m_cause == 2'd2);
            exp_q.push_back(e);
        end
    endtask

    // kind: 0 pass, 1 fail, 2 gpio, 3 pass+gpio, 4 fail+gpio, 5 none (timeout)
    task automatic gen(input int kind, input int inj, input int umode, input int kfix);
        int k;
        int lend;
        for (int n = 0; n < N; n++) begin
            e_wv[n] = 1'b0;
            e_wa[n] = SA;
            e_wd[n] = C_TEST;
            e_gp[n] = $urandom;
            if (e_gp[n] == SIG) e_gp[n] = ~SIG;
            e_ut[n] = 1'b1;
            if ($urandom_range(3) == 0) begin
                e_wv[n] = 1'b1;
                case ($urandom_range(2))
                    0:       e_wa[n] = SA;
                    1:       e_wa[n] = SA + 32'd4;
                    default: e_wa[n] = $urandom | 32'h100;
                endcase
                case ($urandom_range(5))
                    0:       e_wd[n] = C_TEST;
                    1:       e_wd[n] = C_WFI;
                    2:       e_wd[n] = C_BOOT;
                    3:       e_wd[n] = 16'($urandom);
                    4:       e_wd[n] = C_PASS;
                    default: e_wd[n] = C_FAIL;
                endcase
                if (n < inj && e_wa[n] == SA && (e_wd[n] == C_PASS || e_wd[n] == C_FAIL))
                    e_wd[n] = C_WFI;
            end
            if (n > inj && $urandom_range(7) == 0) e_gp[n] = SIG;
        end
        if (inj < N) begin
            if (kind == 0 || kind == 3) begin e_wv[inj] = 1'b1; e_wa[inj] = SA; e_wd[inj] = C_PASS; end
            if (kind == 1 || kind == 4) begin e_wv[inj] = 1'b1; e_wa[inj] = SA; e_wd[inj] = C_FAIL; end
            if (kind >= 2 && kind <= 4) e_gp[inj] = SIG;
        end
        k    = (kfix > 0) ? kfix : $urandom_range(U - 1, 3);
        lend = $urandom_range(130, 60);
        for (int n = 0; n < lend; n++) begin
            if (umode == 1 && (n % k) == 0) e_ut[n] = 1'b0;
            if (umode == 2) e_ut[n] = 1'($urandom_range(1));
        end
    endtask

    task automatic drive(input int n);
        wr_valid_i = e_wv[n];
        wr_addr_i  = e_wa[n];
        wr_data_i  = e_wd[n];
        gpio_i     = e_gp[n];
        uart_tx_i  = e_ut[n];
    endtask

    task automatic drive_idle();
        wr_valid_i = 1'b0;
        wr_addr_i  = '0;
        wr_data_i  = '0;
        gpio_i     = '0;
        uart_tx_i  = 1'b1;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_rst_status"}, status_o, 0);
        check({tag, "_rst_done"}, test_done_o, 0);
        check({tag, "_rst_passed"}, test_passed_o, 0);
        check({tag, "_rst_cause"}, end_cause_o, 0);
        check({tag, "_rst_finish"}, finish_req_o, 0);
        check({tag, "_rst_cycles"}, cycle_count_o, 0);
    endtask

    task automatic run_episode(input int rst_at);
        int stop;
        stop = (rst_at < N) ? rst_at : N;
        @(negedge clk_sys);
        rst_sys_n = 1'b1;
        drive(0);
        for (int n = 1; n < stop; n++) begin
            @(negedge clk_sys);
            drive(n);
        end
        if (stop == N) begin
            @(posedge clk_sys);
            #2;
            check("final_status", status_o, last_status(N - 1));
        end
        @(negedge clk_sys);
        rst_sys_n = 1'b0;
        drive_idle();
        #1;
        reset_checks((stop == N) ? "ep_end" : "mid_flush");
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_events: got %0d outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk_sys);
    endtask

    // Monitor: pops one expectation on every rising test_done_o / finish_req_o.
    initial begin
        bit   pd;
        bit   pf;
        exp_t e;
        pd = 1'b0;
        pf = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            if (rst_sys_n) begin
                if (test_done_o && !pd) begin
                    if (exp_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_done: got done at cycle %0d expected none", ep_cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_order", e.is_fin, 0);
                        check("done_cycle", ep_cyc, e.cyc);
                        check("done_cycle_count", cycle_count_o, ep_cyc);
                        check("done_status", status_o, e.status);
                        check("done_cause", end_cause_o, e.cause);
                        check("done_passed", test_passed_o, e.passed);
                        check("done_no_finish", finish_req_o, 0);
                    end
                end
                if (finish_req_o && !pf) begin
                    if (exp_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_finish: got finish at cycle %0d expected none", ep_cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("fin_order", e.is_fin, 1);
                        check("fin_cycle", ep_cyc, e.cyc);
                        check("fin_status", status_o, e.status);
                        check("fin_cause", end_cause_o, e.cause);
                        check("fin_done", test_done_o, 1);
                    end
                end
            end
            pd = test_done_o;
            pf = finish_req_o;
        end
    end

    initial begin
        int kind;
        int inj;
        int umode;
        int kfix;
        int rst_at;
        rst_sys_n = 1'b1;
        drive_idle();
        #2;
        rst_sys_n = 1'b0;
        #1;
        reset_checks("init");
        repeat (2) @(negedge clk_sys);

        for (int ep = 0; ep < NEP; ep++) begin
            kind   = $urandom_range(5);
            inj    = $urandom_range(110, 3);
            umode  = $urandom_range(2);
            kfix   = 0;
            rst_at = N;
            case (ep)
                0: begin kind = 0; inj = 12; umode = 0; end
                1: begin kind = 1; inj = 15; umode = 0; end
                2: begin kind = 2; inj = 10; umode = 0; end
                3: begin kind = 5; inj = N;  umode = 0; end
                4: begin kind = 0; inj = TO - 1; umode = 0; end
                5: begin kind = 1; inj = TO - 1; umode = 0; end
                6: begin kind = 0; inj = 8;  umode = 1; kfix = 7; end
                7: begin kind = 0; inj = 3;  umode = 0; end
                8: begin kind = 0; inj = 9;  umode = 0; end
                default: ;
            endcase
            gen(kind, inj, umode, kfix);
            if (ep == 0) begin
                e_wv[6] = 1'b1; e_wa[6] = SA;         e_wd[6] = C_TEST;
                e_wv[8] = 1'b1; e_wa[8] = SA + 32'd4; e_wd[8] = C_FAIL;
            end
            if (ep == 2) begin
                e_wv[30] = 1'b1; e_wa[30] = SA; e_wd[30] = C_FAIL;
            end
            run_model();
            if (ep == 7 && m_f > 2) rst_at = m_f - 2;
            push_expected(rst_at);
            run_episode(rst_at);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
